// File: rtl/debounce_xy_pkg.sv
// Shared definitions for the debounce_xy input-conditioning block.
//   - FSM state encoding used by each per-channel debouncer
//   - default filter length and counter width
package debounce_xy_pkg;

  // Consecutive synchronised samples required before an output flips.
  localparam int DEBOUNCE_CYCLES_DEF = 4;

  // Counter width; 2**CNT_W must exceed the filter length.
  localparam int CNT_W_DEF = 16;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_WAIT   = 1'b1
  } state_t;

endpackage : debounce_xy_pkg

// File: rtl/debounce_bit.sv
// Single-channel debouncer: two-flop synchroniser, STABLE/WAIT filter FSM,
// sample counter, registered output level and registered edge strobes.
//
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   asynchronous active-high reset
//   btn   in   raw asynchronous input
//   out   out  debounced, registered level
//   rise  out  one-cycle pulse in the cycle out becomes 1
//   fall  out  one-cycle pulse in the cycle out becomes 0
//   flip  out  combinational: out will toggle at the next clk edge
//              (lets the parent register a summary strobe with no added latency)
module debounce_bit
  import debounce_xy_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic out,
  output logic rise,
  output logic fall,
  output logic flip
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Final qualifying sample: the synchronised level still differs from out
  // and enough samples at the new level have already been counted.
  assign flip = (state == ST_WAIT) && (s != out) && (cnt == CNT_LAST);

  // NOTE: every register here uses non-blocking assignment so that s1->s and
  // s->FSM read the previous cycle's values, giving a true two-stage pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b0;
      s     <= 1'b0;
      state <= ST_STABLE;
      cnt   <= '0;
      out   <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1   <= btn;
      s    <= s1;
      rise <= 1'b0;
      fall <= 1'b0;

      case (state)
        ST_STABLE: begin
          if (s != out) begin
            state <= ST_WAIT;
            cnt   <= CNT_W'(1);
          end else begin
            cnt <= '0;
          end
        end

        ST_WAIT: begin
          if (s == out) begin
            // Returned to the old level: glitch, restart filtering.
            state <= ST_STABLE;
            cnt   <= '0;
          end else if (flip) begin
            // The old level is ~s here, so the edge direction is just s.
            out   <= s;
            rise  <= s;
            fall  <= ~s;
            state <= ST_STABLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state <= ST_STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule : debounce_bit

// File: rtl/debounce_xy.sv
// Input-conditioning stage for the two-input gate block: debounces two raw
// switch inputs into clean X/Y levels plus edge and change strobes.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   btn_x    in   raw asynchronous input, channel X
//   btn_y    in   raw asynchronous input, channel Y
//   X        out  debounced level, channel X
//   Y        out  debounced level, channel Y
//   x_rise   out  one-cycle pulse, X 0->1
//   x_fall   out  one-cycle pulse, X 1->0
//   y_rise   out  one-cycle pulse, Y 0->1
//   y_fall   out  one-cycle pulse, Y 1->0
//   changed  out  one-cycle pulse when X and/or Y changes, aligned with the edge pulses
module debounce_xy
  import debounce_xy_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_x,
  input  logic btn_y,
  output logic X,
  output logic Y,
  output logic x_rise,
  output logic x_fall,
  output logic y_rise,
  output logic y_fall,
  output logic changed
);

  logic x_flip;
  logic y_flip;

  debounce_bit #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_bit_x (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_x),
    .out  (X),
    .rise (x_rise),
    .fall (x_fall),
    .flip (x_flip)
  );

  debounce_bit #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_bit_y (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_y),
    .out  (Y),
    .rise (y_rise),
    .fall (y_fall),
    .flip (y_flip)
  );

  // Registered from the channels' next-edge flip flags, so changed lands in
  // the same cycle as the rise/fall pulses; simultaneous flips merge into one pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      changed <= 1'b0;
    end else begin
      changed <= x_flip | y_flip;
    end
  end

endmodule : debounce_xy

// File: tb/tb_debounce_xy.sv
// Directed self-checking bench for debounce_xy (DEBOUNCE_CYCLES=4, clk 10 ns).
// Inputs are driven and outputs sampled on the falling clock edge.
// Observed vector order: {X, Y, x_rise, x_fall, y_rise, y_fall, changed}.
module tb_debounce_xy;

  logic clk = 1'b0;
  logic rst;
  logic btn_x;
  logic btn_y;
  logic X, Y, x_rise, x_fall, y_rise, y_fall, changed;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  debounce_xy #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_x   (btn_x),
    .btn_y   (btn_y),
    .X       (X),
    .Y       (Y),
    .x_rise  (x_rise),
    .x_fall  (x_fall),
    .y_rise  (y_rise),
    .y_fall  (y_fall),
    .changed (changed)
  );

  function automatic logic [6:0] obs();
    return {X, Y, x_rise, x_fall, y_rise, y_fall, changed};
  endfunction

  task automatic check(input string tag, input logic [6:0] expected);
    logic [6:0] observed;
    observed = obs();
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic nedge();
    @(negedge clk);
  endtask

  // Wait n falling edges, checking a constant expected vector at each one.
  task automatic hold_check(input string tag, input int n, input logic [6:0] expected);
    for (int i = 0; i < n; i++) begin
      nedge();
      check(tag, expected);
    end
  endtask

  initial begin
    // ---------------- Reset with both buttons high ----------------
    rst   = 1'b1;
    btn_x = 1'b1;
    btn_y = 1'b1;
    #2;
    check("reset_async_no_edge", 7'b0000000);
    hold_check("reset_held", 3, 7'b0000000);
    rst = 1'b0;  // next posedge is the first post-reset sampling edge k
    hold_check("post_reset_filtering", 5, 7'b0000000);
    nedge();
    check("post_reset_flip", 7'b1110101);
    nedge();
    check("post_reset_pulse_end", 7'b1100000);

    // Return both to 0 (both fall on the same edge).
    btn_x = 1'b0;
    btn_y = 1'b0;
    hold_check("both_release_filtering", 5, 7'b1100000);
    nedge();
    check("both_release_flip", 7'b0001011);
    nedge();
    check("both_release_pulse_end", 7'b0000000);

    // ---------------- Clean press on X ----------------
    btn_x = 1'b1;
    hold_check("press_filtering", 5, 7'b0000000);
    nedge();
    check("press_flip", 7'b1010001);
    nedge();
    check("press_pulse_end", 7'b1000000);

    // ---------------- Release X ----------------
    btn_x = 1'b0;
    hold_check("release_filtering", 5, 7'b1000000);
    nedge();
    check("release_flip", 7'b0001001);
    nedge();
    check("release_pulse_end", 7'b0000000);

    // ---------------- Bounce rejection ----------------
    btn_x = 1'b1;
    hold_check("bounce_hi1", 2, 7'b0000000);
    btn_x = 1'b0;
    hold_check("bounce_lo", 1, 7'b0000000);
    btn_x = 1'b1;
    hold_check("bounce_hi2", 2, 7'b0000000);
    btn_x = 1'b0;
    hold_check("bounce_settle", 8, 7'b0000000);
    btn_x = 1'b1;
    hold_check("bounce_final_filtering", 5, 7'b0000000);
    nedge();
    check("bounce_final_flip", 7'b1010001);
    nedge();
    check("bounce_final_pulse_end", 7'b1000000);

    // ---------------- Simultaneous press ----------------
    btn_x = 1'b0;
    hold_check("sim_prep_x_high", 5, 7'b1000000);
    nedge();
    check("sim_prep_x_fall", 7'b0001001);
    hold_check("sim_prep_idle", 2, 7'b0000000);
    btn_x = 1'b1;
    btn_y = 1'b1;
    hold_check("sim_filtering", 5, 7'b0000000);
    nedge();
    check("sim_flip", 7'b1110101);
    nedge();
    check("sim_pulse_end", 7'b1100000);

    // ---------------- Reset mid-count on Y ----------------
    btn_x = 1'b0;
    btn_y = 1'b0;
    hold_check("midrst_prep_high", 5, 7'b1100000);
    nedge();
    check("midrst_prep_fall", 7'b0001011);
    hold_check("midrst_prep_idle", 2, 7'b0000000);
    btn_y = 1'b1;
    hold_check("midrst_counting", 3, 7'b0000000);
    rst = 1'b1;
    #1;
    check("midrst_assert", 7'b0000000);
    hold_check("midrst_during", 2, 7'b0000000);
    rst = 1'b0;
    hold_check("midrst_after_filtering", 5, 7'b0000000);
    nedge();
    check("midrst_after_flip", 7'b0100101);
    nedge();
    check("midrst_after_pulse_end", 7'b0100000);

    // ---------------- Async clear of a high output ----------------
    #2;
    rst = 1'b1;
    #1;
    check("async_clear_between_edges", 7'b0000000);
    hold_check("async_clear_held", 2, 7'b0000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_debounce_xy
